// File: rtl/or_gate.sv
// Two-input OR with a registered copy, edge pulses and a saturating
// high-cycle counter.
//
// Ports:
//   clk      - rising-edge clock for every register
//   rst      - asynchronous active-high reset, clears every register
//   a, b     - OR operands
//   clr      - synchronous clear of high_cnt and cnt_sat
//   y        - combinational a | b
//   y_q      - y registered on each rising edge
//   y_rise   - one-cycle pulse when y_q goes 0 -> 1
//   y_fall   - one-cycle pulse when y_q goes 1 -> 0
//   high_cnt - saturating count of cycles with y_q = 1
//   cnt_sat  - high while high_cnt is all-ones
module or_gate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             y_q_q;
  logic             y_q_d;
  logic             y_dly_q;
  logic             y_dly_d;
  logic             y_rise_q;
  logic             y_rise_d;
  logic             y_fall_q;
  logic             y_fall_d;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_cnt_d;
  logic             cnt_sat_q;
  logic             cnt_sat_d;

  assign y = a | b;

  always_comb begin
    y_q_d      = y;
    y_dly_d    = y_q_q;
    // Pulses are registered from y_q against its delayed copy, so they
    // trail an input change by two edges.
    y_rise_d   = y_q_q & ~y_dly_q;
    y_fall_d   = ~y_q_q & y_dly_q;
    high_cnt_d = high_cnt_q;
    if (clr) begin
      high_cnt_d = '0;
    end else if (y_q_q && (high_cnt_q != CNT_MAX)) begin
      high_cnt_d = high_cnt_q + CNT_ONE;
    end
    // Flag follows the next count value so it lines up with high_cnt.
    cnt_sat_d  = (high_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_q      <= 1'b0;
      y_dly_q    <= 1'b0;
      y_rise_q   <= 1'b0;
      y_fall_q   <= 1'b0;
      high_cnt_q <= '0;
      cnt_sat_q  <= 1'b0;
    end else begin
      y_q_q      <= y_q_d;
      y_dly_q    <= y_dly_d;
      y_rise_q   <= y_rise_d;
      y_fall_q   <= y_fall_d;
      high_cnt_q <= high_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
    end
  end

  assign y_q      = y_q_q;
  assign y_rise   = y_rise_q;
  assign y_fall   = y_fall_q;
  assign high_cnt = high_cnt_q;
  assign cnt_sat  = cnt_sat_q;

endmodule

// File: tb/tb_or_gate.sv
// Directed bench for or_gate with CNT_W = 4.
// Each task drives one scenario and checks its own results.
module tb_or_gate;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         clr = 1'b0;
  logic         y;
  logic         y_q;
  logic         y_rise;
  logic         y_fall;
  logic [W-1:0] high_cnt;
  logic         cnt_sat;

  int n_chk = 0;
  int n_fail = 0;

  or_gate #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .y(y), .y_q(y_q), .y_rise(y_rise), .y_fall(y_fall),
    .high_cnt(high_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    logic [1:0] ab [7] = '{2'b00, 2'b01, 2'b10, 2'b11,
                           2'b00, 2'b11, 2'b01};
    logic       ey [7] = '{1'b0, 1'b1, 1'b1, 1'b1,
                           1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      {a, b} = ab[i];
      #20;
      n_chk++;
      if (y !== ey[i]) begin
        n_fail++;
        $display("FAIL sweep[%0d] ab=%b y=%b expected %b",
                 i, ab[i], y, ey[i]);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    a = 1'b1;
    b = 1'b1;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({y, y_q, y_rise, y_fall, high_cnt, cnt_sat} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold y=%b y_q=%b r=%b f=%b cnt=%0d sat=%b expected y=1 rest 0",
               y, y_q, y_rise, y_fall, high_cnt, cnt_sat);
    end
    tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (y_q !== 1'b1 || y_rise !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel1 y_q=%b rise=%b expected 1 0", y_q, y_rise);
    end
    tick();
    n_chk++;
    if (y_rise !== 1'b1 || high_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_rel2 rise=%b cnt=%0d expected 1 1", y_rise, high_cnt);
    end
    tick();
    n_chk++;
    if (y_rise !== 1'b0 || y_fall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel3 rise=%b fall=%b expected 0 0", y_rise, y_fall);
    end
  endtask

  task automatic test_edges();
    int rises = 0;
    int falls = 0;
    a = 1'b0;
    b = 1'b0;
    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    a = 1'b1;
    b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        a = 1'b0;
        b = 1'b0;
      end
      tick();
      rises += int'(y_rise);
      falls += int'(y_fall);
      n_chk++;
      if (y_rise && y_fall) begin
        n_fail++;
        $display("FAIL edges_both cycle %0d rise=1 fall=1 expected not both", i);
      end
    end
    n_chk++;
    if (rises != 1 || falls != 1) begin
      n_fail++;
      $display("FAIL edges_count rises=%0d falls=%0d expected 1 1", rises, falls);
    end
    n_chk++;
    if (high_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL edges_cnt cnt=%0d expected 3", high_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] ec;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ec = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      n_chk++;
      if (high_cnt !== ec || cnt_sat !== (ec == 4'd15)) begin
        n_fail++;
        $display("FAIL sat[%0d] cnt=%0d sat=%b expected %0d %b",
                 k, high_cnt, cnt_sat, ec, ec == 4'd15);
      end
    end
  endtask

  task automatic test_clear();
    clr = 1'b1;
    tick();
    n_chk++;
    if (high_cnt !== 4'd0 || cnt_sat !== 1'b0 || y_q !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_prio cnt=%0d sat=%b y_q=%b expected 0 0 1",
               high_cnt, cnt_sat, y_q);
    end
    clr = 1'b0;
    tick();
    n_chk++;
    if (high_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_resume1 cnt=%0d expected 1", high_cnt);
    end
    tick();
    n_chk++;
    if (high_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL clr_resume2 cnt=%0d expected 2", high_cnt);
    end
  endtask

  task automatic test_async_mid();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    n_chk++;
    if (high_cnt !== 4'd7) begin
      n_fail++;
      $display("FAIL mid_pre cnt=%0d expected 7", high_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({y, y_q, y_rise, y_fall, high_cnt, cnt_sat} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst y=%b y_q=%b r=%b f=%b cnt=%0d sat=%b expected y=1 rest 0",
               y, y_q, y_rise, y_fall, high_cnt, cnt_sat);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (y_q !== 1'b1 || y_rise !== 1'b0 || high_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_rel1 y_q=%b rise=%b cnt=%0d expected 1 0 0",
               y_q, y_rise, high_cnt);
    end
    tick();
    n_chk++;
    if (y_rise !== 1'b1 || high_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_rel2 rise=%b cnt=%0d expected 1 1", y_rise, high_cnt);
    end
  endtask

  task automatic test_glitch();
    a = 1'b0;
    b = 1'b0;
    repeat (3) tick();
    #1;
    b = 1'b1;
    #1;
    n_chk++;
    if (y !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_y y=%b expected 1", y);
    end
    #2;
    b = 1'b0;
    tick();
    n_chk++;
    if (y_q !== 1'b0 || y_rise !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reg y_q=%b rise=%b expected 0 0", y_q, y_rise);
    end
    tick();
    n_chk++;
    if (y_rise !== 1'b0 || y_fall !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_edge rise=%b fall=%b expected 0 0", y_rise, y_fall);
    end
  endtask

  initial begin
    test_sweep();
    test_reset();
    test_edges();
    test_saturation();
    test_clear();
    test_async_mid();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/or_gate.md
OR_GATE -- requirements
Module: or_gate

Interface
REQ-001 Parameter: CNT_W, 16, width of the high-cycle counter (legal range 4..32).
REQ-002 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high; clears all registers immediately on assertion.
REQ-004 Port: a  input  1  first OR operand.
REQ-005 Port: b  input  1  second OR operand.
REQ-006 Port: y  output  1  combinational a OR b.
REQ-007 Port: y_q  output  1  registered copy of y.
REQ-008 Port: y_rise  output  1  one-cycle pulse on a 0->1 transition of y_q.
REQ-009 Port: y_fall  output  1  one-cycle pulse on a 1->0 transition of y_q.
REQ-010 Port: high_cnt  output  CNT_W  saturating count of cycles in which y_q = 1.
REQ-011 Port: cnt_sat  output  1  high when high_cnt equals all-ones.
REQ-012 Port: clr  input  1  synchronous clear of high_cnt and cnt_sat.

Function
REQ-013 y SHALL equal a | b combinationally at all times, with no dependence on clk or rst; truth table 00->0, 01->1, 10->1, 11->1.
REQ-014 y SHALL settle within one delta of any input change, with no clock required, so that an unclocked bench stepping a/b every 20 ns observes correct y.
REQ-015 y_q SHALL take the value of y at each rising clk edge (latency 1 cycle).
REQ-016 y_rise SHALL be 1 for exactly one cycle when y_q goes from 0 to 1; y_fall SHALL be 1 for exactly one cycle when y_q goes from 1 to 0; the two SHALL never both be 1.
REQ-017 Edge detection SHALL compare y_q against a one-cycle-delayed copy of y_q (total latency 2 cycles from an input change).
REQ-018 high_cnt SHALL increment by 1 on each rising edge where y_q = 1 and clr = 0.
REQ-019 high_cnt SHALL saturate at 2^CNT_W-1 and hold without wrap-around; cnt_sat SHALL be 1 while high_cnt is all-ones.
REQ-020 clr = 1 SHALL load high_cnt with 0 and cnt_sat with 0 on the next edge, taking priority over an increment in the same cycle.
REQ-021 Input changes between clock edges SHALL affect only y; glitches shorter than a clock period SHALL NOT affect the registered outputs unless present at an edge.

Reset
REQ-022 While rst = 1: y_q = 0, y_rise = 0, y_fall = 0, high_cnt = 0, cnt_sat = 0, and the delayed copy of y_q = 0.
REQ-023 y SHALL remain a | b during reset.
REQ-024 Reset assertion mid-operation SHALL clear the registers immediately, without waiting for a clock edge; after release, the first edge samples y normally and an edge pulse appears only if y_q transitions from the reset value 0.

Verification
REQ-025 Unclocked sweep: a,b = 00,01,10,11,00,11,01, each held 20 ns -> y = 0,1,1,1,0,1,1.
REQ-026 Reset: assert rst with a = b = 1 -> y = 1 and y_q = 0 and high_cnt = 0 immediately; release -> y_q = 1 after 1 edge and y_rise pulses 1 cycle on the following edge.
REQ-027 Edges: hold y = 1 for 3 cycles, then a = b = 0 -> exactly one y_rise and one y_fall pulse; high_cnt = 3.
REQ-028 Saturation (CNT_W = 4): hold a = 1 for 20 cycles -> high_cnt stops at 15 with cnt_sat = 1 and no wrap to 0.
REQ-029 Clear priority: clr = 1 while y_q = 1 -> high_cnt = 0 after the edge, then it resumes counting from 1 once clr = 0.
REQ-030 Async reset mid-count: pulse rst between clock edges at high_cnt = 7 -> all registers = 0 before the next edge.
